// File: rtl/id_stage_v2_if.sv
// IF -> ID fetch handshake: instruction, PC and valid from IF, ready back from ID.
interface id_stage_v2_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;

  modport master (output if_valid, if_instr, if_pc, input if_ready);
  modport slave  (input if_valid, if_instr, if_pc, output if_ready);
endinterface

// File: rtl/id_stage_v2.sv
// RISC-V ID stage: IF/ID register, decoder, register file and load-use stall FSM.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writeback data to the read ports.
module id_stage_v2 #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  id_stage_v2_if.slave     ifb,
  input  logic             flush,
  input  logic [4:0]       rd_ex,
  input  logic             memread_ex,
  input  logic [4:0]       rd_wb,
  input  logic             regwrite_wb,
  input  logic [XLEN-1:0]  write_data_wb,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic             inst30,
  output logic [10:0]      ctrl,
  output logic [XLEN-1:0]  read_data1,
  output logic [XLEN-1:0]  read_data2,
  output logic [XLEN-1:0]  immediate,
  output logic             illegal
);

  localparam int         AW      = $clog2(NREGS);
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  typedef enum logic {RUN, STALL} state_t;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic [1:0] aluop;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic       aluinputpc;
    logic       branchjalx;
    logic       alu2pc;
  } ctrl_t;

  state_t          state;
  logic [1:0]      cnt;
  logic            valid_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] regs [NREGS];

  logic [6:0]      opcode;
  logic [4:0]      f_rs1, f_rs2, f_rd, rs1_idx;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  ctrl_t           c;
  logic            known, use1, use2, wrd, is_lui;
  logic            reg_bad, illegal_raw, hazard, run_ok, wb_ok;

  assign opcode  = instr_q[6:0];
  assign f_rs1   = instr_q[19:15];
  assign f_rs2   = instr_q[24:20];
  assign f_rd    = instr_q[11:7];
  assign rs1_idx = is_lui ? 5'd0 : f_rs1;

  assign imm_i = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{(XLEN-13){instr_q[31]}}, instr_q[31], instr_q[7],
                  instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){instr_q[31]}}, instr_q[31:12], 12'h000};
  assign imm_j = {{(XLEN-21){instr_q[31]}}, instr_q[31], instr_q[19:12],
                  instr_q[20], instr_q[30:21], 1'b0};

  always_comb begin
    c      = '0;
    known  = 1'b1;
    use1   = 1'b0;
    use2   = 1'b0;
    wrd    = 1'b0;
    is_lui = 1'b0;
    imm    = '0;
    case (opcode)
      7'b0110011: begin c.aluop = 2'b10; c.regwrite = 1'b1; use1 = 1'b1; use2 = 1'b1; wrd = 1'b1; end
      7'b0010011: begin c.aluop = 2'b11; c.alusrc = 1'b1; c.regwrite = 1'b1; use1 = 1'b1; wrd = 1'b1; imm = imm_i; end
      7'b0000011: begin
        c.memread = 1'b1; c.memtoreg = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1;
        use1 = 1'b1; wrd = 1'b1; imm = imm_i;
      end
      7'b0100011: begin c.memwrite = 1'b1; c.alusrc = 1'b1; use1 = 1'b1; use2 = 1'b1; imm = imm_s; end
      7'b1100011: begin c.branch = 1'b1; c.aluop = 2'b01; use1 = 1'b1; use2 = 1'b1; imm = imm_b; end
      7'b1101111: begin
        c.branchjalx = 1'b1; c.aluinputpc = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1;
        wrd = 1'b1; imm = imm_j;
      end
      7'b1100111: begin
        c.branchjalx = 1'b1; c.alu2pc = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1;
        use1 = 1'b1; wrd = 1'b1; imm = imm_i;
      end
      7'b0110111: begin c.alusrc = 1'b1; c.regwrite = 1'b1; wrd = 1'b1; is_lui = 1'b1; imm = imm_u; end
      7'b0010111: begin c.aluinputpc = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1; wrd = 1'b1; imm = imm_u; end
      default:    known = 1'b0;
    endcase
  end

  // Only indices the instruction actually uses can make it illegal on RV32E.
  assign reg_bad = (use1 && {1'b0, f_rs1} >= NREGS_L) ||
                   (use2 && {1'b0, f_rs2} >= NREGS_L) ||
                   (wrd  && {1'b0, f_rd}  >= NREGS_L);
  assign illegal_raw = !known || reg_bad;

  assign hazard = valid_q && memread_ex && (rd_ex != 5'd0) &&
                  ((use1 && rd_ex == rs1_idx) || (use2 && rd_ex == f_rs2));
  assign run_ok = valid_q && (state == RUN);

  assign ifb.if_ready = (state == RUN) && !hazard;
  assign ctrl         = (run_ok && !hazard && !illegal_raw) ? c : '0;
  assign illegal      = run_ok && illegal_raw;
  assign id_valid     = valid_q;
  assign id_pc        = pc_q;
  assign rs1          = rs1_idx;
  assign rs2          = f_rs2;
  assign rd           = f_rd;
  assign funct3       = instr_q[14:12];
  assign inst30       = instr_q[30];
  assign immediate    = imm;

  assign wb_ok = regwrite_wb && (rd_wb != 5'd0) && ({1'b0, rd_wb} < NREGS_L);

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (rs1_idx != 5'd0 && {1'b0, rs1_idx} < NREGS_L) read_data1 = regs[rs1_idx[AW-1:0]];
    if (f_rs2   != 5'd0 && {1'b0, f_rs2}   < NREGS_L) read_data2 = regs[f_rs2[AW-1:0]];
`ifdef ID_WB_BYPASS_EN
    if (wb_ok && rd_wb == rs1_idx) read_data1 = write_data_wb;
    if (wb_ok && rd_wb == f_rs2)   read_data2 = write_data_wb;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[AW'(i)] <= '0;
    end else if (wb_ok) begin
      regs[rd_wb[AW-1:0]] <= write_data_wb;
    end
  end

  // Flush beats stall and capture; a stall holds the IF/ID register untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      cnt     <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= 32'h0000_0013;
    end else if (flush) begin
      state   <= RUN;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            state <= STALL;
            cnt   <= 2'(LOAD_LAT - 1);
          end else if (ifb.if_valid) begin
            instr_q <= ifb.if_instr[31:0];
            pc_q    <= ifb.if_pc;
            valid_q <= 1'b1;
          end else begin
            valid_q <= 1'b0;
          end
        end
        STALL: begin
          if (cnt == 2'd0) state <= RUN;
          else             cnt   <= cnt - 2'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_id_stage_v2.sv
// Directed plus randomized bench for id_stage_v2 (RV32E build, two-cycle load latency).
module tb_id_stage_v2;
  localparam int XLEN = 32, NREGS = 16, LOAD_LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, memread_ex, regwrite_wb;
  logic [4:0] rd_ex, rd_wb;
  logic [31:0] write_data_wb;
  logic id_valid, inst30, illegal;
  logic [31:0] id_pc, read_data1, read_data2, immediate;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] funct3;
  logic [10:0] ctrl;

  id_stage_v2_if #(.XLEN(XLEN)) ifb ();

  id_stage_v2 #(.XLEN(XLEN), .NREGS(NREGS), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .rst(rst), .ifb(ifb), .flush(flush),
    .rd_ex(rd_ex), .memread_ex(memread_ex),
    .rd_wb(rd_wb), .regwrite_wb(regwrite_wb), .write_data_wb(write_data_wb),
    .id_valid(id_valid), .id_pc(id_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .funct3(funct3), .inst30(inst30), .ctrl(ctrl),
    .read_data1(read_data1), .read_data2(read_data2),
    .immediate(immediate), .illegal(illegal)
  );

  int tests = 0, fails = 0;
  logic [31:0] ref_regs [32];
  logic [31:0] snap [32];
  logic        exp_valid;
  logic [31:0] exp_instr, exp_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode, written from the opcode table.
  function automatic logic [10:0] m_ctrl(input logic [31:0] i);
    logic br, mr, mtr, mw, as, rw, aipc, bj, a2pc;
    logic [1:0] op;
    {br, mr, mtr, mw, as, rw, aipc, bj, a2pc} = '0;
    op = 2'b00;
    case (i[6:0])
      7'h33: begin op = 2'b10; rw = 1; end
      7'h13: begin op = 2'b11; as = 1; rw = 1; end
      7'h03: begin mr = 1; mtr = 1; as = 1; rw = 1; end
      7'h23: begin mw = 1; as = 1; end
      7'h63: begin br = 1; op = 2'b01; end
      7'h6f: begin bj = 1; aipc = 1; as = 1; rw = 1; end
      7'h67: begin bj = 1; a2pc = 1; as = 1; rw = 1; end
      7'h37: begin as = 1; rw = 1; end
      7'h17: begin aipc = 1; as = 1; rw = 1; end
      default: ;
    endcase
    return {br, mr, mtr, op, mw, as, rw, aipc, bj, a2pc};
  endfunction

  function automatic logic m_known(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
  endfunction

  function automatic logic m_use1(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic logic m_use2(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  function automatic logic m_wrd(input logic [31:0] i);
    return i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h6f, 7'h67, 7'h37, 7'h17};
  endfunction

  function automatic logic m_illegal(input logic [31:0] i);
    return !m_known(i) || (m_use1(i) && i[19:15] >= NREGS) ||
           (m_use2(i) && i[24:20] >= NREGS) || (m_wrd(i) && i[11:7] >= NREGS);
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    logic signed [11:0] v12;
    logic signed [12:0] v13;
    logic signed [20:0] v21;
    logic signed [31:0] r;
    r = 0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: begin v12 = i[31:20]; r = v12; end
      7'h23: begin v12 = {i[31:25], i[11:7]}; r = v12; end
      7'h63: begin v13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; r = v13; end
      7'h37, 7'h17: r = {i[31:12], 12'h000};
      7'h6f: begin v21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; r = v21; end
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] m_rs1(input logic [31:0] i);
    return (i[6:0] == 7'h37) ? 5'd0 : i[19:15];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    return (idx == 0 || idx >= NREGS) ? 32'h0 : ref_regs[idx];
  endfunction

  // Advance model and DUT one edge while the stage is running hazard-free.
  task automatic step();
    if (flush) exp_valid = 1'b0;
    else if (ifb.if_valid) begin exp_valid = 1'b1; exp_instr = ifb.if_instr; exp_pc = ifb.if_pc; end
    else exp_valid = 1'b0;
    if (regwrite_wb && rd_wb != 0 && rd_wb < NREGS) ref_regs[rd_wb] = write_data_wb;
    @(posedge clk); #1;
    regwrite_wb = 1'b0;
    flush = 1'b0;
    #1;
  endtask

  task automatic check_all(input string t);
    logic ill;
    ill = m_illegal(exp_instr);
    chk({t, ".id_valid"}, id_valid, exp_valid);
    if (exp_valid) chk({t, ".id_pc"}, id_pc, exp_pc);
    chk({t, ".ctrl"}, ctrl, (exp_valid && !ill) ? m_ctrl(exp_instr) : 11'h0);
    chk({t, ".illegal"}, illegal, exp_valid && ill);
    chk({t, ".imm"}, immediate, m_imm(exp_instr));
    chk({t, ".rs1"}, rs1, m_rs1(exp_instr));
    chk({t, ".rs2"}, rs2, exp_instr[24:20]);
    chk({t, ".rd"}, rd, exp_instr[11:7]);
    chk({t, ".funct3"}, funct3, exp_instr[14:12]);
    chk({t, ".inst30"}, inst30, exp_instr[30]);
    chk({t, ".rd1"}, read_data1, m_read(m_rs1(exp_instr)));
    chk({t, ".rd2"}, read_data2, m_read(exp_instr[24:20]));
    chk({t, ".if_ready"}, ifb.if_ready, 1'b1);
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    ifb.if_valid = 1'b1; ifb.if_instr = instr; ifb.if_pc = pc;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    regwrite_wb = 1'b1; rd_wb = r; write_data_wb = d;
  endtask

  initial begin
    logic [31:0] r, instr;
    logic [6:0] ops [11];
    logic [31:0] exp_byp;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h7f, 7'h0b};

    rst = 1'b0; flush = 1'b0; memread_ex = 1'b0; rd_ex = '0;
    regwrite_wb = 1'b0; rd_wb = '0; write_data_wb = '0;
    ifb.if_valid = 1'b0; ifb.if_instr = '0; ifb.if_pc = '0;
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    exp_valid = 1'b0; exp_instr = 32'h13; exp_pc = '0;

    #12;
    chk("reset.id_valid", id_valid, 1'b0);
    chk("reset.ctrl", ctrl, 11'h0);
    chk("reset.illegal", illegal, 1'b0);
    chk("reset.id_pc", id_pc, 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #2;
    check_all("idle");

    // Writeback then decode ADD x7,x5,x0
    wb(5'd5, 32'hDEADBEEF); step();
    present(32'h000283B3, 32'h100); step();
    ifb.if_valid = 1'b0;
    check_all("add");
    chk("add.ctrl_lit", ctrl, 11'h088);
    chk("add.rd1_lit", read_data1, 32'hDEADBEEF);

    // Same-cycle write and read of x9 through ADD x10,x9,x0
    present(32'h00048533, 32'h104); step();
    ifb.if_valid = 1'b0;
`ifdef ID_WB_BYPASS_EN
    exp_byp = 32'hCAFEF00D;
`else
    exp_byp = ref_regs[9];
`endif
    wb(5'd9, 32'hCAFEF00D); #1;
    chk("bypass.rd1", read_data1, exp_byp);
    step();
    check_all("after_wb");

    for (int n = 0; n < 150; n++) begin
      r = $urandom();
      instr = {r[31:7], ops[$urandom_range(0, 10)]};
      ifb.if_valid = ($urandom_range(0, 7) != 0);
      ifb.if_instr = instr;
      ifb.if_pc = $urandom() & 32'hFFFF_FFFC;
      flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1) wb(5'($urandom_range(0, 31)), $urandom());
      step();
      check_all($sformatf("rand%0d", n));
    end

    present(32'hFE000CE3, 32'h200); step();
    check_all("beq");
    chk("beq.imm_lit", immediate, 32'hFFFFFFF8);
    chk("beq.ctrl_lit", ctrl, 11'h440);
    present(32'h123451B7, 32'h204); step();
    check_all("lui");
    chk("lui.rs1_lit", rs1, 5'd0);
    chk("lui.imm_lit", immediate, 32'h12345000);

    // Load-use hazard on rs1 of ADD x8,x6,x2
    wb(5'd6, 32'h11111111); step();
    wb(5'd2, 32'h22222222); step();
    present(32'h00230433, 32'h300); step();
    present(32'h00500093, 32'h304);
    memread_ex = 1'b1; rd_ex = 5'd6; #1;
    chk("haz.if_ready", ifb.if_ready, 1'b0);
    chk("haz.ctrl", ctrl, 11'h0);
    @(posedge clk); #1;
    memread_ex = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      #1;
      chk($sformatf("stall%0d.if_ready", k), ifb.if_ready, 1'b0);
      chk($sformatf("stall%0d.ctrl", k), ctrl, 11'h0);
      chk($sformatf("stall%0d.rd", k), rd, 5'd8);
      @(posedge clk); #1;
    end
    #1;
    check_all("stall_done");
    step();
    check_all("after_stall");

    memread_ex = 1'b1; rd_ex = 5'd0; #1;
    chk("haz_x0.if_ready", ifb.if_ready, 1'b1);
    rd_ex = 5'd1; #1;
    chk("haz_rd.if_ready", ifb.if_ready, 1'b1);
    memread_ex = 1'b0;

    // rs2 hazard on SW x7,8(x4), then flush while stalled
    present(32'h00722423, 32'h308); step();
    ifb.if_valid = 1'b0;
    memread_ex = 1'b1; rd_ex = 5'd7; #1;
    chk("haz_rs2.if_ready", ifb.if_ready, 1'b0);
    @(posedge clk); #1;
    memread_ex = 1'b0; flush = 1'b1; #1;
    chk("stall_flush.pre", ifb.if_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; exp_valid = 1'b0; #1;
    chk("stall_flush.id_valid", id_valid, 1'b0);
    chk("stall_flush.if_ready", ifb.if_ready, 1'b1);
    chk("stall_flush.ctrl", ctrl, 11'h0);
    present(32'h000283B3, 32'h30C); flush = 1'b1; step();
    ifb.if_valid = 1'b0;
    check_all("flush_capture");

    // Register index beyond RV32E
    present(32'h00208A33, 32'h400); step();
    ifb.if_valid = 1'b0;
    check_all("x20");
    chk("x20.illegal_lit", illegal, 1'b1);
    chk("x20.ctrl_lit", ctrl, 11'h0);
    for (int i = 0; i < 32; i++) snap[i] = ref_regs[i];
    wb(5'd20, 32'h55555555); step();
    for (int i = 1; i < NREGS; i++) begin
      present(32'(i) << 15 | 32'h33, 32'h500); step();
      check_all($sformatf("rf%0d", i));
      chk($sformatf("rf%0d.snap", i), read_data1, snap[i]);
    end
    ifb.if_valid = 1'b0;

    // Asynchronous reset in the middle of a stall
    present(32'h00230433, 32'h600); step();
    ifb.if_valid = 1'b0;
    memread_ex = 1'b1; rd_ex = 5'd6;
    @(posedge clk); #1;
    memread_ex = 1'b0; #1;
    chk("rst_stall.pre", ifb.if_ready, 1'b0);
    rst = 1'b0; #1;
    chk("rst_stall.if_ready", ifb.if_ready, 1'b1);
    chk("rst_stall.id_valid", id_valid, 1'b0);
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    exp_valid = 1'b0; exp_instr = 32'h13; exp_pc = '0;
    @(negedge clk) rst = 1'b1;
    present(32'h00230433, 32'h700);
    @(posedge clk); #1;
    ifb.if_valid = 1'b0; exp_valid = 1'b1; exp_instr = 32'h00230433; exp_pc = 32'h700; #1;
    check_all("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
